// File: rtl/multdiv_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : multdiv_pkg
//  Description : Shared definitions for the multiply/divide unit: the
//                divider FSM state encoding, iteration count, cycle counter
//                width, overflow operand constants and a magnitude helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package multdiv_pkg;

  // Divider control states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } div_state_e;

  // One quotient bit is produced per iteration.
  localparam int DIV_ITERS = 32;

  // Width of the iteration counter; must cover DIV_ITERS-1.
  localparam int CTR_W = 5;

  // The single signed quotient that does not fit in 32 bits:
  // 0x80000000 / -1.
  localparam logic [31:0] OVF_DIVIDEND = 32'h8000_0000;
  localparam logic [31:0] OVF_DIVISOR  = 32'hFFFF_FFFF;

  // Magnitude of a two's complement value, returned as unsigned.
  // 0x80000000 maps to 0x80000000, which is correct when read unsigned.
  function automatic logic [31:0] abs32(input logic [31:0] v);
    return v[31] ? (~v + 32'd1) : v;
  endfunction

endpackage : multdiv_pkg
`default_nettype wire

// File: rtl/cycle_ctr5.sv
`default_nettype none
// ============================================================================
//  Module      : cycle_ctr5
//  Description : 5-bit iteration counter with enable and synchronous clear.
//                Flags the final count (31) so the controller knows which
//                iteration is the last one. Counting past 31 wraps to 0.
//  Ports       : clk_i   - clock, rising edge
//                rst_ni  - asynchronous active-low reset (count -> 0)
//                en_i    - advance the count by one this cycle
//                clr_i   - force the count to 0 (wins over en_i)
//                last_o  - high while the count equals 31
//  Revision    : 1.0 - initial release
// ============================================================================
module cycle_ctr5
  import multdiv_pkg::*;
(
  input  logic clk_i,
  input  logic rst_ni,
  input  logic en_i,
  input  logic clr_i,
  output logic last_o
);

  logic [CTR_W-1:0] count_q;
  logic [CTR_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (en_i) begin
      count_d = count_q + CTR_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign last_o = (count_q == CTR_W'(DIV_ITERS - 1));

endmodule : cycle_ctr5
`default_nettype wire

// File: rtl/div_32.sv
`default_nettype none
// ============================================================================
//  Module      : div_32
//  Description : Iterative signed 32-bit restoring divider. A start pulse
//                latches the operand magnitudes and the result sign, then one
//                quotient bit is resolved per cycle for 32 cycles. The
//                quotient truncates toward zero. Divide-by-zero and the
//                0x80000000 / -1 overflow take a fast path with no iterations
//                and raise data_exception.
//  Ports       : clock          - clock, rising edge
//                reset          - asynchronous active-low reset
//                ctrl_DIV       - start pulse (accepted in IDLE or DONE)
//                data_operandA  - dividend, two's complement
//                data_operandB  - divisor, two's complement
//                data_result    - quotient, held until the next completion
//                data_exception - divide-by-zero / overflow flag
//                data_resultRDY - one-cycle result-valid pulse
//                busy           - operation in progress
//  Revision    : 1.0 - initial release
// ============================================================================
module div_32
  import multdiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ctrl_DIV,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             busy
);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  div_state_e  state_q, state_d;
  logic [31:0] rem_q,   rem_d;    // partial remainder
  logic [31:0] quo_q,   quo_d;    // dividend bits shifting out, quotient in
  logic [31:0] dvs_q,   dvs_d;    // divisor magnitude
  logic        neg_q,   neg_d;    // quotient must be negated at the end
  logic        spec_q,  spec_d;   // operation resolved by the fast path
  logic [31:0] res_q,   res_d;
  logic        exc_q,   exc_d;

  // --------------------------------------------------------------------------
  // Operand decode at start
  // --------------------------------------------------------------------------
  logic        start_acc;
  logic        b_zero;
  logic        ovf;

  assign start_acc = ctrl_DIV && ((state_q == IDLE) || (state_q == DONE));
  assign b_zero    = (data_operandB == 32'd0);
  assign ovf       = (data_operandA == OVF_DIVIDEND) && (data_operandB == OVF_DIVISOR);

  // --------------------------------------------------------------------------
  // Restoring iteration datapath
  // --------------------------------------------------------------------------
  // The remainder is always below the divisor (at most 2^31), so shifting in
  // one dividend bit fits in 32 bits; the extra bit of the 33-bit trial
  // difference is purely the borrow that decides the quotient bit.
  logic [32:0] rem_shift;
  logic [32:0] trial;
  logic        q_bit;
  logic [31:0] rem_next;
  logic [31:0] quo_next;
  logic [31:0] quo_signed;

  assign rem_shift  = {rem_q, quo_q[31]};
  assign trial      = rem_shift - {1'b0, dvs_q};
  assign q_bit      = ~trial[32];
  assign rem_next   = q_bit ? trial[31:0] : rem_shift[31:0];
  assign quo_next   = {quo_q[30:0], q_bit};
  assign quo_signed = neg_q ? (~quo_next + 32'd1) : quo_next;

  // --------------------------------------------------------------------------
  // Iteration counter
  // --------------------------------------------------------------------------
  // Counts only on real iterations. A fast-path operation never advances it,
  // so it is already 0 when the next start arrives. Counting through 31 wraps
  // it to 0 on the edge that enters DONE.
  logic ctr_en;
  logic ctr_last;

  assign ctr_en = (state_q == RUN) && !spec_q;

  cycle_ctr5 u_ctr (
    .clk_i  (clock),
    .rst_ni (reset),
    .en_i   (ctr_en),
    .clr_i  (start_acc),
    .last_o (ctr_last)
  );

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    neg_d   = neg_q;
    spec_d  = spec_q;
    res_d   = res_q;
    exc_d   = exc_q;

    unique case (state_q)
      IDLE, DONE: begin
        if (ctrl_DIV) begin
          rem_d  = 32'd0;
          dvs_d  = abs32(data_operandB);
          neg_d  = data_operandA[31] ^ data_operandB[31];
          spec_d = b_zero || ovf;
          // For the fast path the quotient register carries the final
          // answer directly, so the RUN cycle just publishes it.
          if (b_zero) begin
            quo_d = 32'd0;
          end else if (ovf) begin
            quo_d = OVF_DIVIDEND;
          end else begin
            quo_d = abs32(data_operandA);
          end
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end

      RUN: begin
        if (spec_q) begin
          // Fast path: resolved in the single cycle after the start edge.
          res_d   = quo_q;
          exc_d   = 1'b1;
          state_d = DONE;
        end else begin
          rem_d = rem_next;
          quo_d = quo_next;
          if (ctr_last) begin
            res_d   = quo_signed;
            exc_d   = 1'b0;
            state_d = DONE;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      rem_q   <= 32'd0;
      quo_q   <= 32'd0;
      dvs_q   <= 32'd0;
      neg_q   <= 1'b0;
      spec_q  <= 1'b0;
      res_q   <= 32'd0;
      exc_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
      neg_q   <= neg_d;
      spec_q  <= spec_d;
      res_q   <= res_d;
      exc_q   <= exc_d;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign data_result    = res_q;
  assign data_exception = exc_q;
  assign data_resultRDY = (state_q == DONE);
  assign busy           = (state_q == RUN);

endmodule : div_32
`default_nettype wire
